// File: rtl/cnn_topk_selector.sv
// Top-3 class selector: scans a captured logit vector one class per cycle through a
// sorted 3-entry insertion register and reports classes and Q8.8 scores, best first.
module cnn_topk_selector #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 10,
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] logits,
    input  logic                              logits_valid,
    output logic                              busy,
    output logic                              result_valid,
    output logic                              dropped,
    output logic [3*IDX_W-1:0]                top_class,
    output logic [3*DATA_WIDTH-1:0]           top_score,
    output logic [1:0]                        state_dbg
);

    // Handshake: logits_valid is a one-cycle pulse with no back-pressure. It is accepted
    // in IDLE or DONE (data captured that cycle); in SCAN it is discarded and flagged by a
    // one-cycle dropped pulse on the following cycle. result_valid pulses for one cycle
    // and top_class/top_score hold their value until the next vector completes.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic signed [DATA_WIDTH-1:0] cap      [NUM_CLASSES];
    logic        [IDX_W-1:0]      idx;
    logic        [2:0]            slot_vld;
    logic        [IDX_W-1:0]      slot_cls [3];
    logic signed [DATA_WIDTH-1:0] slot_scr [3];

    logic        [2:0]            nxt_vld;
    logic        [IDX_W-1:0]      nxt_cls  [3];
    logic signed [DATA_WIDTH-1:0] nxt_scr  [3];

    logic                         accept;
    logic                         last_idx;
    logic signed [DATA_WIDTH-1:0] cur_score;
    logic                         ins0, ins1, ins2;

    assign accept    = logits_valid && ((state == IDLE) || (state == DONE));
    assign last_idx  = (idx == IDX_W'(NUM_CLASSES - 1));
    assign cur_score = cap[idx];

    assign busy         = (state == SCAN);
    assign result_valid = (state == DONE);
    assign state_dbg    = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (logits_valid) next_state = SCAN;
            SCAN:    if (last_idx) next_state = DONE;
            DONE:    next_state = logits_valid ? SCAN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strict '>' keeps an earlier (lower-index) class ahead of a later equal score.
    always_comb begin
        ins0 = !slot_vld[0] || (cur_score > slot_scr[0]);
        ins1 = !ins0 && (!slot_vld[1] || (cur_score > slot_scr[1]));
        ins2 = !ins0 && !ins1 && (!slot_vld[2] || (cur_score > slot_scr[2]));

        nxt_vld = slot_vld;
        for (int k = 0; k < 3; k++) begin
            nxt_cls[k] = slot_cls[k];
            nxt_scr[k] = slot_scr[k];
        end

        if (ins0) begin
            nxt_vld    = {slot_vld[1:0], 1'b1};
            nxt_cls[0] = idx;
            nxt_scr[0] = cur_score;
            nxt_cls[1] = slot_cls[0];
            nxt_scr[1] = slot_scr[0];
            nxt_cls[2] = slot_cls[1];
            nxt_scr[2] = slot_scr[1];
        end else if (ins1) begin
            nxt_vld    = {slot_vld[1], 1'b1, slot_vld[0]};
            nxt_cls[1] = idx;
            nxt_scr[1] = cur_score;
            nxt_cls[2] = slot_cls[1];
            nxt_scr[2] = slot_scr[1];
        end else if (ins2) begin
            nxt_vld[2] = 1'b1;
            nxt_cls[2] = idx;
            nxt_scr[2] = cur_score;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            dropped   <= 1'b0;
            slot_vld  <= '0;
            top_class <= '0;
            top_score <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) cap[i] <= '0;
            for (int k = 0; k < 3; k++) begin
                slot_cls[k] <= '0;
                slot_scr[k] <= '0;
            end
        end else begin
            state   <= next_state;
            dropped <= (state == SCAN) && logits_valid;
            if (accept) begin
                for (int i = 0; i < NUM_CLASSES; i++)
                    cap[i] <= logits[i*DATA_WIDTH +: DATA_WIDTH];
                slot_vld <= '0;
                idx      <= '0;
            end else if (state == SCAN) begin
                slot_vld <= nxt_vld;
                for (int k = 0; k < 3; k++) begin
                    slot_cls[k] <= nxt_cls[k];
                    slot_scr[k] <= nxt_scr[k];
                end
                idx <= idx + 1'b1;
                // Results are published only as the final insertion completes.
                if (last_idx) begin
                    for (int k = 0; k < 3; k++) begin
                        top_class[k*IDX_W +: IDX_W]           <= nxt_cls[k];
                        top_score[k*DATA_WIDTH +: DATA_WIDTH] <= nxt_scr[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_topk_selector.sv
// Directed bench for cnn_topk_selector: hand-computed top-3 results, latency, drop,
// mid-scan reset and back-to-back acceptance.
module tb_cnn_topk_selector;

    localparam int DW    = 16;
    localparam int NC    = 10;
    localparam int IDX_W = 4;

    logic                 clk;
    logic                 reset;
    logic [NC*DW-1:0]     logits;
    logic                 logits_valid;
    logic                 busy;
    logic                 result_valid;
    logic                 dropped;
    logic [3*IDX_W-1:0]   top_class;
    logic [3*DW-1:0]      top_score;
    logic [1:0]           state_dbg;

    int checks = 0;
    int errors = 0;

    cnn_topk_selector #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
        .clk          (clk),
        .reset        (reset),
        .logits       (logits),
        .logits_valid (logits_valid),
        .busy         (busy),
        .result_valid (result_valid),
        .dropped      (dropped),
        .top_class    (top_class),
        .top_score    (top_score),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a vector for one cycle, then scramble the input bus and count cycles
    // (starting at the first cycle after the accept edge) until result_valid.
    task automatic run_vec(input logic [NC*DW-1:0] v, output int cyc, output int bcnt);
        logits       = v;
        logits_valid = 1'b1;
        tick();
        logits_valid = 1'b0;
        logits       = ~v;
        cyc  = 1;
        bcnt = busy ? 1 : 0;
        while (!result_valid && cyc < 40) begin
            tick();
            cyc++;
            if (busy) bcnt++;
        end
    endtask

    logic [NC*DW-1:0] v_asc, v_tie, v_neg, v_mix, v_alt;
    int cyc, bcnt;
    logic [3*IDX_W-1:0] held_cls;
    logic [3*DW-1:0]    held_scr;
    int rv_seen;

    initial begin
        for (int i = 0; i < NC; i++) begin
            v_asc[i*DW +: DW] = 16'(i * 16'h0100);
            v_tie[i*DW +: DW] = 16'h0100;
            v_neg[i*DW +: DW] = 16'hF000 + 16'(i);
            v_alt[i*DW +: DW] = 16'h7FFF;
        end
        v_neg[5*DW +: DW] = 16'hFF80;
        v_mix = {16'h0300, 16'h8001, 16'h0051, 16'hFE00, 16'h0300,
                 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0050};

        reset        = 1'b1;
        logits       = '0;
        logits_valid = 1'b0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_result_valid", result_valid, 0);
        check("reset_dropped", dropped, 0);
        check("reset_top_class", top_class, 0);
        check("reset_top_score", top_score, 0);
        check("reset_state", state_dbg, 0);
        reset = 1'b0;
        tick();

        // 1: ascending
        run_vec(v_asc, cyc, bcnt);
        check("asc_latency", cyc, 11);
        check("asc_busy_cycles", bcnt, 10);
        check("asc_top_class", top_class, 12'h789);
        check("asc_top_score", top_score, 48'h0700_0800_0900);
        tick();
        check("asc_rv_one_cycle", result_valid, 0);
        check("asc_held_class", top_class, 12'h789);

        // 2: all equal, tie order
        run_vec(v_tie, cyc, bcnt);
        check("tie_latency", cyc, 11);
        check("tie_top_class", top_class, 12'h210);
        check("tie_top_score", top_score, 48'h0100_0100_0100);
        tick();

        // 3: all negative
        run_vec(v_neg, cyc, bcnt);
        check("neg_top_class", top_class, 12'h895);
        check("neg_top_score", top_score, 48'hF008_F009_FF80);
        tick();

        // 4: mixed sign with extremes, second pulse at scan cycle 4 is dropped
        logits       = v_mix;
        logits_valid = 1'b1;
        tick();
        logits_valid = 1'b0;
        logits       = v_alt;
        tick();
        tick();
        tick();
        check("drop_before", dropped, 0);
        logits_valid = 1'b1;
        tick();
        logits_valid = 1'b0;
        check("drop_pulse", dropped, 1);
        check("drop_busy", busy, 1);
        tick();
        check("drop_one_cycle", dropped, 0);
        cyc = 6;
        while (!result_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("drop_latency", cyc, 11);
        check("drop_top_class", top_class, 12'h953);
        check("drop_top_score", top_score, 48'h0300_0300_7FFF);
        tick();
        check("drop_no_second_result", busy, 0);

        // 5: reset at scan cycle 6
        logits       = v_asc;
        logits_valid = 1'b1;
        tick();
        logits_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_mid_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rv", result_valid, 0);
        check("rst_mid_top_class", top_class, 0);
        check("rst_mid_top_score", top_score, 0);
        tick();
        reset = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (result_valid) rv_seen++;
        end
        check("rst_no_result", rv_seen, 0);
        run_vec(v_mix, cyc, bcnt);
        check("rst_fresh_latency", cyc, 11);
        check("rst_fresh_top_class", top_class, 12'h953);
        check("rst_fresh_top_score", top_score, 48'h0300_0300_7FFF);
        tick();

        // 6: back-to-back, second pulse coincident with result_valid
        run_vec(v_neg, cyc, bcnt);
        check("b2b_first_class", top_class, 12'h895);
        held_cls = top_class;
        held_scr = top_score;
        logits       = v_tie;
        logits_valid = 1'b1;
        tick();
        logits_valid = 1'b0;
        check("b2b_accepted", busy, 1);
        for (int i = 0; i < 5; i++) tick();
        check("b2b_held_class", top_class, 12'h895);
        check("b2b_held_score", top_score, 48'hF008_F009_FF80);
        cyc = 6;
        while (!result_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b_latency", cyc, 11);
        check("b2b_second_class", top_class, 12'h210);
        check("b2b_second_score", top_score, 48'h0100_0100_0100);
        tick();
        check("b2b_idle", state_dbg, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
